// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, reset PC and the fetch FSM state encoding.
package cpu_pkg;
   localparam int unsigned         WORD_W         = 16;
   localparam logic [WORD_W-1:0]   RESET_PC       = 16'h0000;
   localparam logic                ST_REQ_ENC     = 1'b0;
   localparam logic                ST_DELIVER_ENC = 1'b1;

   typedef enum logic {
      S_REQ     = ST_REQ_ENC,
      S_DELIVER = ST_DELIVER_ENC
   } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: next-PC redirect, imem req/ack, decode valid/ready, PC out.
// FETCH_PERF_CNT_EN adds the fetch_count / redirect_count observation signals.
interface fetch_stage_if #(parameter int unsigned WIDTH = cpu_pkg::WORD_W);
   logic [WIDTH-1:0] next_pc_in;
   logic             pc_load;
   logic             stall;
   logic             mem_req;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;
   logic [WIDTH-1:0] instr_out;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]      fetch_count;
   logic [15:0]      redirect_count;
`endif

   modport master (
      input  next_pc_in, pc_load, stall, mem_ack, mem_rdata, instr_ready,
      output mem_req, mem_addr, instr_out, instr_valid, pc_out
`ifdef FETCH_PERF_CNT_EN
      , output fetch_count, redirect_count
`endif
   );

   modport slave (
      output next_pc_in, pc_load, stall, mem_ack, mem_rdata, instr_ready,
      input  mem_req, mem_addr, instr_out, instr_valid, pc_out
`ifdef FETCH_PERF_CNT_EN
      , input fetch_count, redirect_count
`endif
   );
endinterface

// File: rtl/pc_reg.sv
// Program counter register: async reset, load beats increment, wraps modulo 2^WIDTH.
module pc_reg #(
   parameter int unsigned            WIDTH    = cpu_pkg::WORD_W,
   parameter logic [WIDTH-1:0]       RESET_PC = cpu_pkg::RESET_PC,
   parameter int unsigned            PC_STEP  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_pc
);
   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

   logic [WIDTH-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pc <= RESET_PC;
      else if (i_load) r_pc <= i_load_val;
      else if (i_inc)  r_pc <= r_pc + STEP;
   end

   assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack, IR and decode valid/ready handshake.
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter int unsigned      WIDTH    = cpu_pkg::WORD_W,
   parameter logic [WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int unsigned      PC_STEP  = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);
   import cpu_pkg::*;

   fetch_state_t     r_state, w_state_nxt;
   logic             r_req_en;
   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] w_pc;
   logic             w_req, w_valid, w_take;

   // Keeps mem_req low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_req_en <= 1'b0;
      else        r_req_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_REQ;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_valid     = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req = r_req_en & ~bus.stall;
            if (w_req && bus.mem_ack && !bus.pc_load) w_state_nxt = S_DELIVER;
         end
         S_DELIVER: begin
            w_valid = 1'b1;
            if (bus.instr_ready && !bus.stall) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
      if (bus.pc_load) w_state_nxt = S_REQ;
   end

   // An ack only counts against an outstanding request and never alongside a redirect.
   assign w_take = w_req & bus.mem_ack & ~bus.pc_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_ir <= '0;
      else if (w_take) r_ir <= bus.mem_rdata;
   end

   pc_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (bus.pc_load),
      .i_load_val (bus.next_pc_in),
      .i_inc      (w_take),
      .o_pc       (w_pc)
   );

   assign bus.mem_req     = w_req;
   assign bus.mem_addr    = w_pc;
   assign bus.pc_out      = w_pc;
   assign bus.instr_out   = r_ir;
   assign bus.instr_valid = w_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [15:0] r_redir_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_valid && bus.instr_ready && !bus.pc_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (bus.pc_load && r_redir_cnt != 16'hFFFF)     r_redir_cnt <= r_redir_cnt + 16'd1;
      end
   end

   assign bus.fetch_count    = r_fetch_cnt;
   assign bus.redirect_count = r_redir_cnt;
`endif
endmodule
